// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters from ID issue to WB,
// with combinational RAW stall for sources whose write will not be visible in time.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issueValid,
    input  logic        issueRegWrite,
    input  logic [4:0]  issueRd,
    input  logic        useRs,
    input  logic        useRt,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbRd,
    input  logic        cancelValid,
    input  logic [4:0]  cancelRd,
    output logic        stall,
    output logic [31:0] pendingMask,
    output logic        errSticky
);

    localparam int unsigned SW = CNT_W + 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0]    cnt_q [1:31];
    logic [CNT_W-1:0]    cnt_d [1:31];
    logic [CNT_W-1:0]    cnt_rd [32];
    logic [31:0]         pend_q, pend_d;
    logic                err_q, err_d;
    logic [31:0]         inc, dec_wb, dec_c;
    logic signed [SW-1:0] rem_rs, rem_rt, nxt;
    logic                hz_rs, hz_rt;

    // Register 0 is untracked: its slot in the read view is a constant zero.
    always_comb begin
        cnt_rd[0] = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            cnt_rd[r] = cnt_q[5'(r)];
        end
    end

    always_comb begin
        dec_wb = '0;
        dec_c  = '0;
        if (wbRegWrite && wbRd != 5'd0) dec_wb[wbRd] = 1'b1;
        if (cancelValid && cancelRd != 5'd0) dec_c[cancelRd] = 1'b1;
    end

    // Same-cycle retire/cancel counts as resolved: the register file writes on the falling edge.
    always_comb begin
        rem_rs = $signed({2'b00, cnt_rd[rs]}) - $signed(SW'(dec_wb[rs])) - $signed(SW'(dec_c[rs]));
        rem_rt = $signed({2'b00, cnt_rd[rt]}) - $signed(SW'(dec_wb[rt])) - $signed(SW'(dec_c[rt]));
        hz_rs  = useRs && (rs != 5'd0) && (rem_rs > 0);
        hz_rt  = useRt && (rt != 5'd0) && (rem_rt > 0);
        stall  = issueValid && (hz_rs || hz_rt);
    end

    always_comb begin
        inc = '0;
        if (issueValid && !stall && issueRegWrite && issueRd != 5'd0) inc[issueRd] = 1'b1;
    end

    always_comb begin
        err_d  = err_q;
        pend_d = '0;
        nxt    = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            nxt = $signed({2'b00, cnt_q[5'(r)]}) + $signed(SW'(inc[5'(r)]))
                - $signed(SW'(dec_wb[5'(r)])) - $signed(SW'(dec_c[5'(r)]));
            if (nxt < 0) begin
                cnt_d[5'(r)] = '0;
                err_d        = 1'b1;
            end else if (nxt > CNT_MAX) begin
                cnt_d[5'(r)] = '1;
                err_d        = 1'b1;
            end else begin
                cnt_d[5'(r)] = nxt[CNT_W-1:0];
            end
            pend_d[5'(r)] = |cnt_d[5'(r)];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '{default: '0};
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign pendingMask = pend_q;
    assign errSticky   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: reference count model feeds an expected-result
// queue at drive time; registered outputs are popped and compared after each rising edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issueValid, issueRegWrite, useRs, useRt, wbRegWrite, cancelValid;
    logic [4:0]  issueRd, rs, rt, wbRd, cancelRd;
    logic        stall;
    logic [31:0] pendingMask;
    logic        errSticky;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issueValid(issueValid), .issueRegWrite(issueRegWrite), .issueRd(issueRd),
        .useRs(useRs), .useRt(useRt), .rs(rs), .rt(rt),
        .wbRegWrite(wbRegWrite), .wbRd(wbRd),
        .cancelValid(cancelValid), .cancelRd(cancelRd),
        .stall(stall), .pendingMask(pendingMask), .errSticky(errSticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mask;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   mcnt[32];
    logic merr;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rem(input logic [4:0] s);
        return mcnt[s] - int'(wbRegWrite && wbRd == s) - int'(cancelValid && cancelRd == s);
    endfunction

    function automatic logic model_stall();
        logic h_rs, h_rt;
        h_rs = useRs && rs != 5'd0 && rem(rs) > 0;
        h_rt = useRt && rt != 5'd0 && rem(rt) > 0;
        return issueValid && (h_rs || h_rt);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        merr = 1'b0;
        q.delete();
    endtask

    // One clock: drive at negedge, check stall, advance model, compare registered outputs.
    task automatic cyc(input string tag, input logic iv, input logic irw, input logic [4:0] ird,
                       input logic urs, input logic [4:0] rsv, input logic urt, input logic [4:0] rtv,
                       input logic wb, input logic [4:0] wbr, input logic cv, input logic [4:0] cr,
                       input int want_stall);
        logic        st;
        logic [31:0] m;
        exp_t        e;
        int          n;
        @(negedge clk);
        issueValid = iv; issueRegWrite = irw; issueRd = ird;
        useRs = urs; rs = rsv; useRt = urt; rt = rtv;
        wbRegWrite = wb; wbRd = wbr; cancelValid = cv; cancelRd = cr;
        #1;
        st = model_stall();
        chk({tag, ":stall"}, stall, st);
        if (want_stall >= 0) chk({tag, ":stall_c"}, stall, want_stall[0]);
        m = '0;
        for (int r = 1; r < 32; r++) begin
            n = mcnt[r] + int'(iv && !st && irw && ird == r)
                - int'(wb && wbr == r) - int'(cv && cr == r);
            if (n < 0) begin n = 0; merr = 1'b1; end
            if (n > 3) begin n = 3; merr = 1'b1; end
            mcnt[r] = n;
            m[r] = (n != 0);
        end
        e.mask = m; e.err = merr; e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, ":queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            chk({e.tag, ":mask"}, pendingMask, e.mask);
            chk({e.tag, ":err"}, errSticky, e.err);
        end
    endtask

    task automatic idle_inputs();
        issueValid = 0; issueRegWrite = 0; issueRd = 0; useRs = 0; useRt = 0;
        rs = 0; rt = 0; wbRegWrite = 0; wbRd = 0; cancelValid = 0; cancelRd = 0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();

        // Reset held with arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            issueValid = 1; issueRegWrite = 1; issueRd = 5'($urandom_range(1, 31));
            useRs = 1; rs = 5'($urandom_range(1, 31)); useRt = 1; rt = 5'($urandom_range(1, 31));
            wbRegWrite = 1; wbRd = 5'($urandom_range(1, 31));
            cancelValid = 1; cancelRd = 5'($urandom_range(1, 31));
            #1;
            chk("rst:stall", stall, 1'b0);
            chk("rst:mask", pendingMask, 32'd0);
            chk("rst:err", errSticky, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // Asynchronous reset mid-flight.
        cyc("add5", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("add5:mask_c", pendingMask, 32'h20);
        #2;
        issueValid = 1; useRs = 1; rs = 5;
        reset = 1'b0;
        #1;
        chk("async_rst:mask", pendingMask, 32'd0);
        chk("async_rst:stall", stall, 1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // Read-after-write, resolved by same-cycle writeback.
        cyc("raw_issue", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw_stall", 1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
        chk("raw:mask_c", pendingMask, 32'h20);
        cyc("raw_wb", 1, 0, 0, 1, 5, 0, 0, 1, 5, 0, 0, 0);
        chk("raw_wb:mask_c", pendingMask, 32'd0);

        // Register 0 is never tracked.
        cyc("r0_issue", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("r0_read", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("r0:mask_c", pendingMask, 32'd0);

        // Accumulate, net-zero issue+retire, drain.
        for (int i = 0; i < 3; i++) cyc("acc7", 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("acc7_net", 1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        cyc("acc7_wb1", 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, -1);
        cyc("acc7_wb2", 1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 1);
        cyc("acc7_wb2b", 1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 0);
        chk("acc7:mask_c", pendingMask, 32'd0);
        chk("acc7:err_c", errSticky, 1'b0);

        // Cancel clears the hazard in the same cycle.
        cyc("can_issue", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("can_read", 1, 0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0);
        chk("can:mask_c", pendingMask, 32'd0);

        // Underflow, then overflow saturation (four issues must still need three retires).
        cyc("uf3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, -1);
        chk("uf3:err_c", errSticky, 1'b1);
        chk("uf3:mask_c", pendingMask, 32'd0);
        for (int i = 0; i < 4; i++) cyc("ov11", 1, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("ov11_wb1", 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, -1);
        cyc("ov11_wb2", 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, -1);
        chk("ov11:mask_c", pendingMask, 32'h800);
        cyc("ov11_wb3", 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, -1);
        chk("ov11:mask0_c", pendingMask, 32'd0);
        chk("ov11:err_c", errSticky, 1'b1);

        // Random traffic over a few registers to exercise hazards and collisions.
        for (int i = 0; i < 300; i++) begin
            cyc("rnd", 1'($urandom), 1'($urandom), 5'($urandom_range(0, 4)),
                1'($urandom), 5'($urandom_range(0, 4)), 1'($urandom), 5'($urandom_range(0, 4)),
                1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 4)),
                1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 4)), -1);
        end

        // Only reset clears the sticky error.
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("final_rst:err", errSticky, 1'b0);
        chk("final_rst:mask", pendingMask, 32'd0);
        model_reset();
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file scoreboard for the pipelined MIPS core. It tracks in-flight writes to the 32 architectural registers, from instruction issue in ID to the writeback that drives the register file write port. It stalls an issuing instruction whose source registers still have a pending write that will not be visible in time. It sits beside the hazard detection logic in ID. It consumes the same `rd`/`regWrite` writeback signals the register file consumes.

## Interface
- `CNT_W`, default 2: width of the per-register pending-write counter. Maximum pending count is 2^CNT_W−1 = 3.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `issueValid` input 1: an instruction in ID is attempting to issue this cycle.
- `issueRegWrite` input 1: the issuing instruction writes a register.
- `issueRd` input 5: destination register of the issuing instruction.
- `useRs` / `useRt` input 1 each: the issuing instruction reads rs / rt.
- `rs` / `rt` input 5 each: source register numbers.
- `wbRegWrite` input 1: writeback stage writes the register file this cycle.
- `wbRd` input 5: writeback destination register.
- `cancelValid` input 1: an in-flight write is squashed (branch flush) and will never retire.
- `cancelRd` input 5: destination register of the squashed write.
- `stall` output 1: the issuing instruction must be held in ID. Combinational.
- `pendingMask` output 32: bit r = 1 when register r has ≥1 pending write. Registered.
- `errSticky` output 1: counter underflow or overflow has occurred. Registered and sticky.

## Operation
- State: 31 counters, `cnt[1..31]`, each CNT_W bits wide. Register 0 is never tracked; `cnt[0]` reads as 0 and `pendingMask[0]` is tied to 0.
- An issue is accepted when `issueValid && !stall`.
  - inc[r] = accepted && issueRegWrite && issueRd==r && r!=0.
- A retire is dec_wb[r] = wbRegWrite && wbRd==r && r!=0.
- A cancel is dec_c[r] = cancelValid && cancelRd==r && r!=0.
- Next value: next[r] = cnt[r] + inc[r] − dec_wb[r] − dec_c[r]. The computation uses CNT_W+2-bit signed arithmetic.
  - If next < 0, `cnt[r]` is set to 0 and `errSticky` is set.
  - If next > 3, `cnt[r]` is set to 3 and `errSticky` is set.
  - Otherwise `cnt[r]` takes next.
- Simultaneous events on the same register net out. Issue and retire on the same r in the same cycle leave the count unchanged.
- Source hazard, hz(s) = use && s!=0 && (cnt[s] − dec_wb[s] − dec_c[s]) > 0.
  - The register file writes on the falling edge. A write retiring this cycle is therefore visible to the same-cycle ID read, so a count of 1 retiring now is not a hazard.
  - A cancel also removes the pending write for the purpose of hz.
- `stall` = issueValid && (hz(rs) with useRs || hz(rt) with useRt).
- `stall` does not depend on `issueRegWrite` or `issueRd`. There is no combinational path from those inputs to `stall`.
- A stalled cycle increments nothing. The instruction re-presents on the next cycle.
- `errSticky` is cleared only by reset.

## Timing
- Reset: all counters are 0, `pendingMask` = 0, `errSticky` = 0, and therefore `stall` = 0. Reset takes effect immediately and asynchronously, including mid-operation; pending writes are discarded.
- Reset deassertion is sampled synchronously; the first update occurs on the first rising edge after deassertion.
- `pendingMask` and the counters update on the rising edge and reflect events sampled on that edge. Latency is 1 cycle.
- `stall` is combinational from the current counters plus the same-cycle wb/cancel/issue inputs. It has zero latency.
- Back-to-back issues to the same rd accumulate: three issues give `cnt` = 3. A fourth issue saturates the counter and sets `errSticky`. The pipeline depth guarantees this never happens legally.
- Retire or cancel with `cnt` = 0: the counter is ignored (held at 0) and `errSticky` is set.

## Test plan
- Reset check: hold `reset`=0 with arbitrary inputs -> `stall`=0, `pendingMask`=0, `errSticky`=0. Then issue `add $5` and assert reset mid-flight -> `pendingMask[5]` clears immediately.
- Read-after-write stall: issue writing rd=5; the next cycle issue reading rs=5 -> `stall`=1 and `pendingMask`=0x20. Then pulse `wbRegWrite` with `wbRd`=5 -> `stall`=0 in that same cycle, and `pendingMask`=0 on the next edge.
- Register 0: issue with issueRd=0, then read rs=0 -> `pendingMask`=0 and `stall`=0 throughout.
- Accumulate and simultaneous events: three issues to rd=7 -> `cnt`=3. Then one issue plus one retire to rd=7 in the same cycle -> `cnt` stays 3. Then three retires -> `pendingMask[7]`=0 and `errSticky`=0.
- Cancel: issue to rd=9, then `cancelValid` with `cancelRd`=9 while an instruction reading rt=9 issues -> `stall`=0 that cycle and `pendingMask[9]`=0 on the next edge.
- Errors: retire rd=3 with `cnt[3]`=0 -> `cnt[3]` stays 0 and `errSticky`=1. A fourth issue to a saturated counter -> `cnt` stays 3 and `errSticky` remains 1 until reset.
